// File: rtl/sol32_dbus_bridge.sv
// sol32_dbus_bridge: bridges the sol32 core's single-cycle load/store port onto a
// multi-cycle request/acknowledge data bus.
//
// One core access is latched, the core is stalled until the bus acknowledges, and the
// byte lanes are steered in both directions. Misaligned, reserved-width, bus-error and
// timed-out accesses end in a one-cycle Fault pulse.
//
// Ports:
//   Clock, Reset                 rising-edge clock, asynchronous active-low reset
//   ReadEnable, WriteEnable      core load / store request
//   DataWidth                    00 byte, 01 half, 10 word, 11 reserved
//   MemoryAddress, DataOut       core byte address and store data (value in low bits)
//   DataIn                       zero-extended load result
//   Stall                        core must hold its current instruction
//   Fault, FaultAddress          abort pulse and address of the last faulting access
//   BusRequest, BusWrite         bus request and direction (1 = store)
//   BusAddress, BusByteEnable    word address and active byte lanes
//   BusWriteData                 lane-steered store data
//   BusReadData, BusAck, BusError bus response (data and error qualified by BusAck)
module sol32_dbus_bridge #(
  parameter int unsigned TimeoutCycles = 255,
  parameter int unsigned TimeoutWidth  = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReadEnable,
  input  logic        WriteEnable,
  input  logic [1:0]  DataWidth,
  input  logic [31:0] MemoryAddress,
  input  logic [31:0] DataOut,
  output logic [31:0] DataIn,
  output logic        Stall,
  output logic        Fault,
  output logic [31:0] FaultAddress,
  output logic        BusRequest,
  output logic        BusWrite,
  output logic [31:0] BusAddress,
  output logic [3:0]  BusByteEnable,
  output logic [31:0] BusWriteData,
  input  logic [31:0] BusReadData,
  input  logic        BusAck,
  input  logic        BusError
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StReq   = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;
  localparam logic [1:0] StFault = 2'd3;

  localparam logic [TimeoutWidth-1:0] TimeoutLimit = TimeoutWidth'(TimeoutCycles);
  localparam logic [TimeoutWidth-1:0] CountOne     = TimeoutWidth'(1);

  logic [1:0]              state_q, state_d;
  logic                    req_q, req_d;
  logic                    write_q, write_d;
  logic [29:0]             waddr_q, waddr_d;
  logic [1:0]              lo_q, lo_d;
  logic [1:0]              width_q, width_d;
  logic [3:0]              be_q, be_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             data_in_q, data_in_d;
  logic                    fault_q, fault_d;
  logic [31:0]             fault_addr_q, fault_addr_d;
  logic [TimeoutWidth-1:0] count_q, count_d;

  logic        access;
  logic        illegal;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] load_data;
  logic        timeout_hit;

  assign access = ReadEnable | WriteEnable;

  assign illegal = (DataWidth == 2'b11) ||
                   (DataWidth == 2'b01 && MemoryAddress[0]) ||
                   (DataWidth == 2'b10 && MemoryAddress[1:0] != 2'b00) ||
                   (ReadEnable && WriteEnable);

  // Outgoing lane steering; loads drive the same enables but no write data.
  always_comb begin
    be_new    = 4'b0000;
    wdata_new = 32'h0;
    case (DataWidth)
      2'b00: begin
        be_new    = 4'b0001 << MemoryAddress[1:0];
        wdata_new = {4{DataOut[7:0]}};
      end
      2'b01: begin
        be_new    = MemoryAddress[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{DataOut[15:0]}};
      end
      2'b10: begin
        be_new    = 4'b1111;
        wdata_new = DataOut;
      end
      default: begin
        be_new    = 4'b0000;
        wdata_new = 32'h0;
      end
    endcase
    if (!WriteEnable) begin
      wdata_new = 32'h0;
    end
  end

  // Incoming lane steering from the captured width and low address bits.
  always_comb begin
    load_data = 32'h0;
    case (width_q)
      2'b00:   load_data = {24'h0, BusReadData[8*lo_q +: 8]};
      2'b01:   load_data = {16'h0, lo_q[1] ? BusReadData[31:16] : BusReadData[15:0]};
      default: load_data = BusReadData;
    endcase
  end

  // count_d already includes the current REQ cycle.
  assign timeout_hit = (TimeoutCycles != 0) && (count_d == TimeoutLimit);

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    write_d      = write_q;
    waddr_d      = waddr_q;
    lo_d         = lo_q;
    width_d      = width_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    data_in_d    = data_in_q;
    fault_d      = 1'b0;
    fault_addr_d = fault_addr_q;
    count_d      = count_q;
    case (state_q)
      StIdle: begin
        if (access) begin
          if (illegal) begin
            state_d      = StFault;
            fault_d      = 1'b1;
            fault_addr_d = MemoryAddress;
          end else begin
            state_d = StReq;
            req_d   = 1'b1;
            write_d = WriteEnable;
            waddr_d = MemoryAddress[31:2];
            lo_d    = MemoryAddress[1:0];
            width_d = DataWidth;
            be_d    = be_new;
            wdata_d = wdata_new;
            count_d = '0;
          end
        end
      end
      StReq: begin
        count_d = count_q + CountOne;
        if (BusAck) begin
          req_d = 1'b0;
          if (BusError) begin
            state_d      = StFault;
            fault_d      = 1'b1;
            fault_addr_d = {waddr_q, lo_q};
          end else begin
            state_d = StDone;
            if (!write_q) begin
              data_in_d = load_data;
            end
          end
        end else if (timeout_hit) begin
          req_d        = 1'b0;
          state_d      = StFault;
          fault_d      = 1'b1;
          fault_addr_d = {waddr_q, lo_q};
        end
      end
      StDone:  state_d = StIdle;
      StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= StIdle;
      req_q        <= 1'b0;
      write_q      <= 1'b0;
      waddr_q      <= '0;
      lo_q         <= 2'b00;
      width_q      <= 2'b00;
      be_q         <= 4'b0000;
      wdata_q      <= 32'h0;
      data_in_q    <= 32'h0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      write_q      <= write_d;
      waddr_q      <= waddr_d;
      lo_q         <= lo_d;
      width_q      <= width_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      data_in_q    <= data_in_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      count_q      <= count_d;
    end
  end

  assign Stall         = (state_q == StIdle && access) || (state_q == StReq);
  assign Fault         = fault_q;
  assign FaultAddress  = fault_addr_q;
  // The last load result is kept through a fault; only the fault cycle itself reads 0.
  assign DataIn        = (state_q == StFault) ? 32'h0 : data_in_q;
  assign BusRequest    = req_q;
  assign BusWrite      = write_q;
  assign BusAddress    = {waddr_q, 2'b00};
  assign BusByteEnable = be_q;
  assign BusWriteData  = wdata_q;

endmodule
